fpu_issue_queue: RTL and testbench

- Parametrised front-end between the core's FP execute stage and the fp_wrapper APU port.
- Buffers up to DEPTH tagged FP requests and resolves dynamic rounding against frm_i.
- Issues requests over req/gnt, tracks in-flight ops by credit, and returns in-order tagged results with valid/ready backpressure.
- Replaces the direct single-request hookup; adds queueing, tags, illegal-rounding-mode handling and result buffering.

---
 rtl/fpu_issue_pkg.sv | 32 +++
 rtl/fpu_issue_queue_sync_fifo.sv | 52 +++++
 rtl/fpu_issue_queue.sv | 145 ++++++++++++++
 tb/tb_fpu_issue_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared types, encodings and helpers for the FP issue queue.
package fpu_issue_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } issue_state_e;

  // Flag vector layout is {NV,DZ,OF,UF,NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN     = 32'h7FC0_0000;
  localparam logic [4:0]  INVALID_FLAGS = 5'(1 << FLAG_NV);

  function automatic logic rm_is_legal(input logic [2:0] rm);
    return (rm <= 3'(RM_RMM));
  endfunction

endpackage

// File: rtl/fpu_issue_queue_sync_fifo.sv
// Show-ahead synchronous FIFO; head is visible the cycle after it is written.
// Pointers carry an extra MSB so full/empty fall out of the difference; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Empty reads as zero so downstream data outputs are clean after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fpu_issue_queue.sv
// Tagged FP request queue feeding the APU req/gnt port, with credit-limited issue and an in-order result buffer.
// Enqueue-to-request latency 1 cycle; rvalid-to-out_valid 1 cycle; out_ready stalls free credits, a full queue drops in_ready.
module fpu_issue_queue
  import fpu_issue_pkg::*;
#(
  parameter int unsigned FLEN            = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TAG_W           = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [FLEN-1:0]          in_op_a_i,
  input  logic [FLEN-1:0]          in_op_b_i,
  input  logic [FLEN-1:0]          in_op_c_i,
  input  logic [4:0]               in_op_i,
  input  logic [2:0]               in_rm_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  input  logic [2:0]               frm_i,
  output logic                     fpu_req_o,
  input  logic                     fpu_gnt_i,
  output logic [3*FLEN-1:0]        fpu_operands_o,
  output logic [4:0]               fpu_op_o,
  output logic [2:0]               fpu_rm_o,
  input  logic                     fpu_rvalid_i,
  input  logic [FLEN-1:0]          fpu_rdata_i,
  input  logic [4:0]               fpu_rflags_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [FLEN-1:0]          out_data_o,
  output logic [4:0]               out_flags_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  // Credits bound occupancy to MAX_OUTSTANDING, so rounding the buffers up to a power of 2 is safe.
  localparam int unsigned RES_DEPTH = (MAX_OUTSTANDING < 2) ? 2 : (1 << $clog2(MAX_OUTSTANDING));
  localparam int unsigned RES_CNT_W = $clog2(RES_DEPTH) + 1;

  typedef struct packed {
    logic [FLEN-1:0]  a;
    logic [FLEN-1:0]  b;
    logic [FLEN-1:0]  c;
    logic [4:0]       op;
    logic [2:0]       rm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } req_entry_t;

  typedef struct packed {
    logic [FLEN-1:0]  data;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } res_entry_t;

  req_entry_t           enq_entry, head;
  res_entry_t           res_wdata, res_head;
  logic                 q_full, q_empty, q_pop;
  logic                 tag_full, tag_empty;
  logic [TAG_W-1:0]     tag_head;
  logic [RES_CNT_W-1:0] in_flight, res_count;
  logic                 res_full, res_empty, res_push, res_pop;
  logic                 credit_ok, head_ok, accept, ill_pop, rv_take;
  logic [2:0]           rm_res;
  issue_state_e         state_q, state_d;

  assign rm_res    = (in_rm_i == 3'(RM_DYN)) ? frm_i : in_rm_i;
  assign enq_entry = '{a: in_op_a_i, b: in_op_b_i, c: in_op_c_i, op: in_op_i,
                       rm: rm_res, illegal: !rm_is_legal(rm_res), tag: in_tag_i};
  assign in_ready_o = !q_full;

  sync_fifo #(.WIDTH($bits(req_entry_t)), .DEPTH(DEPTH)) u_req_q (
    .clk_i, .rst_i,
    .push_i (in_valid_i && !q_full), .wdata_i(enq_entry),
    .pop_i  (q_pop), .rdata_o(head),
    .full_o (q_full), .empty_o(q_empty), .count_o(count_o)
  );

  // The tag FIFO occupancy is the in-flight count.
  sync_fifo #(.WIDTH(TAG_W), .DEPTH(RES_DEPTH)) u_tag_q (
    .clk_i, .rst_i,
    .push_i (accept), .wdata_i(head.tag),
    .pop_i  (rv_take), .rdata_o(tag_head),
    .full_o (tag_full), .empty_o(tag_empty), .count_o(in_flight)
  );

  sync_fifo #(.WIDTH($bits(res_entry_t)), .DEPTH(RES_DEPTH)) u_res_q (
    .clk_i, .rst_i,
    .push_i (res_push), .wdata_i(res_wdata),
    .pop_i  (res_pop), .rdata_o(res_head),
    .full_o (res_full), .empty_o(res_empty), .count_o(res_count)
  );

  assign credit_ok = (32'(in_flight) + 32'(res_count)) < 32'(MAX_OUTSTANDING);
  assign head_ok   = !q_empty && !head.illegal && credit_ok;

  always_comb begin
    state_d   = state_q;
    fpu_req_o = 1'b0;
    case (state_q)
      ST_IDLE: if (head_ok) begin
        fpu_req_o = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: if (head_ok) fpu_req_o = 1'b1;
               else         state_d   = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // An illegal head retires only once the pipe is drained, which keeps results in order.
  assign ill_pop = (state_q == ST_IDLE) && !q_empty && head.illegal && tag_empty && credit_ok;
  assign accept  = fpu_req_o && fpu_gnt_i;
  assign q_pop   = accept || ill_pop;
  assign rv_take = fpu_rvalid_i && !tag_empty;

  always_comb begin
    res_wdata = '{data: fpu_rdata_i, flags: fpu_rflags_i, tag: tag_head};
    if (ill_pop) res_wdata = '{data: FLEN'(CANON_NAN), flags: INVALID_FLAGS, tag: head.tag};
  end

  assign res_push = rv_take || ill_pop;
  assign res_pop  = out_valid_o && out_ready_i;

  assign fpu_operands_o = fpu_req_o ? {head.c, head.b, head.a} : '0;
  assign fpu_op_o       = fpu_req_o ? head.op : '0;
  assign fpu_rm_o       = fpu_req_o ? head.rm : '0;

  assign out_valid_o = !res_empty;
  assign out_data_o  = res_head.data;
  assign out_flags_o = res_head.flags;
  assign out_tag_o   = res_head.tag;

  a_rvalid_has_tag: assert property (@(posedge clk_i) disable iff (rst_i) fpu_rvalid_i |-> !tag_empty);
  a_tag_room:       assert property (@(posedge clk_i) disable iff (rst_i) accept |-> !tag_full);
  a_res_room:       assert property (@(posedge clk_i) disable iff (rst_i) res_push |-> !res_full);

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed scenarios plus a randomized run against a queue-level model of the issue queue.
module tb_fpu_issue_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, fpu_req, fpu_gnt, fpu_rvalid, out_valid, out_ready;
  logic [31:0] op_a, op_b, op_c, fpu_rdata, out_data;
  logic [4:0]  in_op, fpu_op, fpu_rflags, out_flags;
  logic [2:0]  in_rm, frm, fpu_rm;
  logic [3:0]  in_tag, out_tag;
  logic [95:0] fpu_operands;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a, b, c;
    logic [4:0]  op;
    logic [2:0]  rm;
    bit          ill;
    logic [3:0]  tag;
  } mreq_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  flags;
    logic [3:0]  tag;
  } mres_t;

  fpu_issue_queue dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_a_i(op_a), .in_op_b_i(op_b), .in_op_c_i(op_c),
    .in_op_i(in_op), .in_rm_i(in_rm), .in_tag_i(in_tag), .frm_i(frm),
    .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt), .fpu_operands_o(fpu_operands),
    .fpu_op_o(fpu_op), .fpu_rm_o(fpu_rm),
    .fpu_rvalid_i(fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_flags_o(out_flags), .out_tag_o(out_tag), .count_o(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    in_valid = 0; op_a = 0; op_b = 0; op_c = 0; in_op = 0; in_rm = 0; in_tag = 0; frm = 0;
    fpu_gnt = 0; fpu_rvalid = 0; fpu_rdata = 0; fpu_rflags = 0; out_ready = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    next_cycle(); next_cycle();
    rst = 0;
  endtask

  task automatic push_req(input logic [3:0] tag, input logic [31:0] a, input logic [2:0] rm);
    in_valid = 1; in_tag = tag; op_a = a; op_b = a + 32'h10; op_c = a + 32'h20; in_rm = rm; in_op = 5'(tag);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (fpu_req !== 1'b0)  begin errors++; $display("FAIL reset_req: got %b want 0", fpu_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (fpu_operands !== 96'h0) begin errors++; $display("FAIL reset_operands: got %h want 0", fpu_operands); end
  endtask

  task automatic test_single_add();
    do_reset();
    push_req(4'd5, 32'h3F80_0000, 3'b000);
    op_b = 32'h4000_0000; op_c = 32'h0;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b want 0", fpu_req); end
    next_cycle(); in_valid = 0; fpu_gnt = 1;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", fpu_req); end
    checks++; if (fpu_operands !== {32'h0, 32'h4000_0000, 32'h3F80_0000})
      begin errors++; $display("FAIL single_operands: got %h want %h", fpu_operands, {32'h0, 32'h4000_0000, 32'h3F80_0000}); end
    checks++; if (fpu_rm !== 3'b000) begin errors++; $display("FAIL single_rm: got %b want 000", fpu_rm); end
    next_cycle(); fpu_gnt = 0;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b0) begin errors++; $display("FAIL single_req_after_gnt: got %b want 0", fpu_req); end
    next_cycle(); next_cycle();
    fpu_rvalid = 1; fpu_rdata = 32'h4040_0000; fpu_rflags = 5'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_out_early: got %b want 0", out_valid); end
    next_cycle(); fpu_rvalid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h4040_0000) begin errors++; $display("FAIL single_out_data: got %h want 40400000", out_data); end
    checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL single_out_tag: got %0d want 5", out_tag); end
    next_cycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_out_popped: got %b want 0", out_valid); end
  endtask

  task automatic test_dyn_rm();
    do_reset();
    push_req(4'd1, 32'h11, 3'b111); frm = 3'b010;
    next_cycle(); in_valid = 0; frm = 3'b000;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b1) begin errors++; $display("FAIL dyn_req: got %b want 1", fpu_req); end
    checks++; if (fpu_rm !== 3'b010) begin errors++; $display("FAIL dyn_rm: got %b want 010", fpu_rm); end
    next_cycle(); frm = 3'b001;
    @(negedge clk);
    checks++; if (fpu_rm !== 3'b010) begin errors++; $display("FAIL dyn_rm_held: got %b want 010", fpu_rm); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_req(4'(i), 32'hA0 + 32'(i), 3'b000);
      @(negedge clk);
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, in_ready, (i < 4)); end
      checks++; if (count !== 3'(i)) begin errors++; $display("FAIL full_count[%0d]: got %0d want %0d", i, count, i); end
      if (i > 0) begin
        checks++; if (fpu_req !== 1'b1 || fpu_operands[31:0] !== 32'hA0)
          begin errors++; $display("FAIL full_req_stable[%0d]: got req=%b a=%h want req=1 a=a0", i, fpu_req, fpu_operands[31:0]); end
      end
      next_cycle();
    end
    in_valid = 0;
    @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count_final: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_final: got %b want 0", in_ready); end
  endtask

  task automatic test_credit();
    logic [31:0] granted[$];
    do_reset();
    out_ready = 0; fpu_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) push_req(4'(7 + i), 32'h107 + 32'(i), 3'b000);
      else in_valid = 0;
      @(negedge clk);
      if (fpu_req && fpu_gnt) granted.push_back(fpu_operands[31:0]);
      next_cycle();
    end
    checks++; if (granted.size() != 2) begin errors++; $display("FAIL credit_grants: got %0d want 2", granted.size()); end
    checks++; if (granted.size() != 2 || granted[0] !== 32'h107 || granted[1] !== 32'h108)
      begin errors++; $display("FAIL credit_grant_order: got %0d grants want 107,108", granted.size()); end
    fpu_gnt = 0; fpu_rvalid = 1; fpu_rdata = 32'hD7;
    next_cycle(); fpu_rdata = 32'hD8;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd7) begin errors++; $display("FAIL credit_first_result: got v=%b tag=%0d want v=1 tag=7", out_valid, out_tag); end
    next_cycle(); fpu_rvalid = 0;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b0) begin errors++; $display("FAIL credit_blocked: got %b want 0", fpu_req); end
    next_cycle(); out_ready = 1;
    @(negedge clk);
    checks++; if (out_tag !== 4'd7 || out_data !== 32'hD7) begin errors++; $display("FAIL credit_pop7: got tag=%0d data=%h want 7/d7", out_tag, out_data); end
    next_cycle(); out_ready = 0; fpu_gnt = 1;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b1 || fpu_operands[31:0] !== 32'h109)
      begin errors++; $display("FAIL credit_third_issue: got req=%b a=%h want 1/109", fpu_req, fpu_operands[31:0]); end
    checks++; if (out_tag !== 4'd8) begin errors++; $display("FAIL credit_head8: got %0d want 8", out_tag); end
    next_cycle(); fpu_gnt = 0; fpu_rvalid = 1; fpu_rdata = 32'hD9;
    next_cycle(); fpu_rvalid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if (out_tag !== 4'd8 || out_data !== 32'hD8) begin errors++; $display("FAIL credit_pop8: got tag=%0d data=%h want 8/d8", out_tag, out_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (out_tag !== 4'd9 || out_data !== 32'hD9) begin errors++; $display("FAIL credit_pop9: got tag=%0d data=%h want 9/d9", out_tag, out_data); end
  endtask

  task automatic test_illegal();
    do_reset();
    fpu_gnt = 1;
    push_req(4'd1, 32'h1, 3'b000); next_cycle();
    push_req(4'd2, 32'h2, 3'b000); next_cycle();
    push_req(4'd3, 32'h3, 3'b101); next_cycle();
    in_valid = 0;
    for (int c = 3; c < 10; c++) begin
      fpu_rvalid = (c == 5 || c == 6);
      fpu_rdata  = (c == 5) ? 32'hD1 : 32'hD2;
      @(negedge clk);
      checks++; if (fpu_req !== 1'b0) begin errors++; $display("FAIL illegal_no_req[c%0d]: got %b want 0", c, fpu_req); end
      if (c == 4) begin
        checks++; if (count !== 3'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_waits: got count=%0d v=%b want 1/0", count, out_valid); end
      end
      if (c == 6) begin
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_data !== 32'hD1) begin errors++; $display("FAIL illegal_res1: got tag=%0d data=%h", out_tag, out_data); end
      end
      if (c == 7) begin
        checks++; if (out_tag !== 4'd2 || out_data !== 32'hD2) begin errors++; $display("FAIL illegal_res2: got tag=%0d data=%h", out_tag, out_data); end
      end
      if (c == 8) begin
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_data !== 32'h7FC0_0000 || out_flags !== 5'b10000)
          begin errors++; $display("FAIL illegal_nan: got v=%b tag=%0d data=%h flags=%b want 1/3/7fc00000/10000", out_valid, out_tag, out_data, out_flags); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL illegal_popped: got %0d want 0", count); end
      end
      if (c == 9) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_drained: got %b want 0", out_valid); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      push_req(4'(c), 32'h40 + 32'(c), 3'b000);
      fpu_gnt = (c == 1); fpu_rvalid = (c == 2);
      next_cycle();
    end
    in_valid = 0; fpu_gnt = 0; fpu_rvalid = 0;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b1 || out_valid !== 1'b1 || count !== 3'd3)
      begin errors++; $display("FAIL midrst_pre: got req=%b v=%b count=%0d want 1/1/3", fpu_req, out_valid, count); end
    rst = 1;
    next_cycle(); rst = 0;
    @(negedge clk);
    checks++; if (fpu_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", fpu_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    mreq_t rq[$];
    logic [3:0] inf[$];
    mres_t rs[$];
    mreq_t nr;
    mres_t nres;
    bit exp_req, enq, iss, ill, rv, opop;
    logic [2:0] rres;
    logic [3:0] rtag;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      op_a = $urandom(); op_b = $urandom(); op_c = $urandom();
      in_op     = 5'($urandom());
      in_rm     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      frm       = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      in_tag    = 4'($urandom());
      fpu_gnt   = ($urandom_range(0, 1) == 1);
      fpu_rvalid = (inf.size() > 0) && ($urandom_range(0, 2) != 0);
      fpu_rdata = $urandom(); fpu_rflags = 5'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_req = (rq.size() > 0) && !rq[0].ill && (inf.size() + rs.size() < MAXO);
      checks++; if (in_ready !== (rq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, (rq.size() < DEPTH)); end
      checks++; if (count !== 3'(rq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc, count, rq.size()); end
      checks++; if (fpu_req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", cyc, fpu_req, exp_req); end
      if (exp_req) begin
        checks++; if (fpu_operands !== {rq[0].c, rq[0].b, rq[0].a} || fpu_op !== rq[0].op || fpu_rm !== rq[0].rm)
          begin errors++; $display("FAIL rnd_fields[%0d]: got %h/%h/%b want %h/%h/%b", cyc, fpu_operands, fpu_op, fpu_rm,
                                   {rq[0].c, rq[0].b, rq[0].a}, rq[0].op, rq[0].rm); end
      end
      checks++; if (out_valid !== (rs.size() > 0)) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", cyc, out_valid, (rs.size() > 0)); end
      if (rs.size() > 0) begin
        checks++; if (out_data !== rs[0].data || out_flags !== rs[0].flags || out_tag !== rs[0].tag)
          begin errors++; $display("FAIL rnd_out[%0d]: got %h/%b/%0d want %h/%b/%0d", cyc, out_data, out_flags, out_tag,
                                   rs[0].data, rs[0].flags, rs[0].tag); end
      end
      enq  = in_valid && (rq.size() < DEPTH);
      iss  = exp_req && fpu_gnt;
      ill  = (rq.size() > 0) && rq[0].ill && (inf.size() == 0) && (rs.size() < MAXO);
      rv   = fpu_rvalid && (inf.size() > 0);
      opop = (rs.size() > 0) && out_ready;
      if (opop) void'(rs.pop_front());
      if (rv) begin
        rtag = inf.pop_front();
        nres.data = fpu_rdata; nres.flags = fpu_rflags; nres.tag = rtag;
        rs.push_back(nres);
      end
      if (iss) inf.push_back(rq[0].tag);
      if (ill) begin
        nres.data = 32'h7FC0_0000; nres.flags = 5'b10000; nres.tag = rq[0].tag;
        rs.push_back(nres);
      end
      if (iss || ill) void'(rq.pop_front());
      if (enq) begin
        rres = (in_rm == 3'b111) ? frm : in_rm;
        nr.a = op_a; nr.b = op_b; nr.c = op_c; nr.op = in_op; nr.rm = rres;
        nr.ill = (rres > 3'd4); nr.tag = in_tag;
        rq.push_back(nr);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_dyn_rm();
    test_full();
    test_credit();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
